// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RV-style core: sequences fetch, decode, execute,
// memory and writeback, and bounds every memory handshake with a timeout.
module multicycle_control #(
  parameter int WORDSIZE       = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  input  logic        dmem_ready,
  output logic        ir_write_en,
  output logic        pc_write_en,
  output logic        rf_write_en,
  output logic        dm_write_en,
  output logic [1:0]  pc_src,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic        finished,
  output logic        illegal,
  output logic        bus_error,
  output logic [2:0]  state,
  output logic [31:0] instr_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_RW     = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMMW   = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t        state_reg;
  logic [6:0]    opcode_reg;
  logic [CW-1:0] wait_reg;
  logic [31:0]   instr_count_reg;
  logic          illegal_reg;
  logic          bus_error_reg;
  logic          opcode_legal;
  logic          unused_wordsize;

  // Datapath width has no bearing on sequencing.
  assign unused_wordsize = (WORDSIZE > 0);

  assign opcode_legal = opcode inside {OP_R, OP_RW, OP_IMM, OP_IMMW, OP_LOAD, OP_STORE,
                                       OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM};

  assign state       = state_reg;
  assign instr_count = instr_count_reg;
  assign illegal     = illegal_reg;
  assign bus_error   = bus_error_reg;
  assign finished    = (state_reg == S_HALT);

  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    ir_write_en = 1'b0;
    pc_write_en = 1'b0;
    rf_write_en = 1'b0;
    dm_write_en = 1'b0;
    pc_src      = 2'b00;
    wb_sel      = 2'b00;
    alu_src_b   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        imem_req    = 1'b1;
        ir_write_en = imem_ready;
      end
      S_EXEC: begin
        alu_src_b = !(opcode_reg inside {OP_R, OP_RW, OP_BRANCH});
        if (opcode_reg == OP_BRANCH) begin
          pc_write_en = 1'b1;
          pc_src      = branch_taken ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (opcode_reg == OP_STORE && dmem_ready) begin
          dm_write_en = 1'b1;
          pc_write_en = 1'b1;
        end
      end
      S_WB: begin
        rf_write_en = 1'b1;
        pc_write_en = 1'b1;
        case (opcode_reg)
          OP_LOAD: wb_sel = 2'b01;
          OP_JAL: begin
            wb_sel = 2'b10;
            pc_src = 2'b01;
          end
          OP_JALR: begin
            wb_sel = 2'b10;
            pc_src = 2'b10;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      opcode_reg      <= '0;
      wait_reg        <= '0;
      instr_count_reg <= '0;
      illegal_reg     <= 1'b0;
      bus_error_reg   <= 1'b0;
    end else begin
      // pc_write_en is the single retirement marker.
      if (pc_write_en) instr_count_reg <= instr_count_reg + 32'd1;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_FETCH;
            wait_reg  <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ready) begin
            state_reg <= S_DECODE;
            wait_reg  <= '0;
          end else if (wait_reg == WAIT_LAST) begin
            state_reg     <= S_HALT;
            bus_error_reg <= 1'b1;
          end else begin
            wait_reg <= wait_reg + CW'(1);
          end
        end
        S_DECODE: begin
          opcode_reg <= opcode;
          if (opcode == OP_SYSTEM) begin
            state_reg <= S_HALT;
          end else if (!opcode_legal) begin
            state_reg   <= S_HALT;
            illegal_reg <= 1'b1;
          end else begin
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (opcode_reg == OP_BRANCH) begin
            state_reg <= S_FETCH;
            wait_reg  <= '0;
          end else if (opcode_reg == OP_LOAD || opcode_reg == OP_STORE) begin
            state_reg <= S_MEM;
            wait_reg  <= '0;
          end else begin
            state_reg <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            state_reg <= (opcode_reg == OP_STORE) ? S_FETCH : S_WB;
            wait_reg  <= '0;
          end else if (wait_reg == WAIT_LAST) begin
            state_reg     <= S_HALT;
            bus_error_reg <= 1'b1;
          end else begin
            wait_reg <= wait_reg + CW'(1);
          end
        end
        S_WB: begin
          state_reg <= S_FETCH;
          wait_reg  <= '0;
        end
        S_HALT: state_reg <= S_HALT;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WORDSIZE, default 64: datapath word width; no internal effect, kept for instantiation symmetry.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum wait cycles for any memory handshake.
REQ-003 Port clk  in  1: single clock; all state updates on the rising edge.
REQ-004 Port reset  in  1: reset is synchronous and active-high.
REQ-005 Port start  in  1: begin execution; sampled only in IDLE.
REQ-006 Port opcode  in  7: bits [6:0] of the instruction register, valid from DECODE onward.
REQ-007 Port branch_taken  in  1: datapath compare result, valid in EXEC.
REQ-008 Ports imem_req out 1 / imem_ready in 1: instruction fetch handshake.
REQ-009 Ports dmem_req out 1 / dmem_ready in 1: data access handshake.
REQ-010 Ports ir_write_en, pc_write_en, rf_write_en, dm_write_en  out  1 each: datapath write strobes.
REQ-011 Port pc_src  out  2: 00 pc+4, 01 pc+imm (branch/jal), 10 rs1+imm (jalr).
REQ-012 Port wb_sel  out  2: 00 ALU, 01 memory, 10 pc+4.
REQ-013 Port alu_src_b  out  1: 0 rs2, 1 immediate.
REQ-014 Ports finished, illegal, bus_error  out  1 each: status flags.
REQ-015 Port state  out  3; port instr_count  out  32: debug state and retired-instruction count.

Function
REQ-016 The states SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Outputs are combinational from state, latched opcode (opcode_q) and handshake inputs.
REQ-017 IDLE: start=1 -> FETCH; otherwise stay.
REQ-018 FETCH: imem_req=1; on imem_ready=1, ir_write_en=1 for that cycle only, -> DECODE. imem_req SHALL stay high until ready.
REQ-019 DECODE: opcode_q <= opcode. Legal set: 0110011, 0111011, 0010011, 0011011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011. 1110011 -> HALT with illegal=0; any other value -> HALT with illegal=1; else -> EXEC.
REQ-020 EXEC: alu_src_b=0 for 0110011/0111011/1100011, else 1. Branch: pc_write_en=1, pc_src=01 if branch_taken else 00, -> FETCH. Load/store -> MEM. All others -> WB.
REQ-021 MEM: dmem_req=1 until dmem_ready. Store: dm_write_en=1 only in the dmem_ready cycle, plus pc_write_en=1, pc_src=00, -> FETCH. Load: on dmem_ready -> WB.
REQ-022 WB: rf_write_en=1, pc_write_en=1, for one cycle, then -> FETCH. Load: wb_sel=01, pc_src=00. jal: wb_sel=10, pc_src=01. jalr: wb_sel=10, pc_src=10. Others: wb_sel=00, pc_src=00.
REQ-023 pc_write_en SHALL pulse exactly once per retired instruction. instr_count increments by 1 on that same edge and wraps from 0xFFFFFFFF to 0.
REQ-024 Minimum latencies with ready in the first request cycle: branch 3 cycles, store 4, ALU/lui/auipc/jal/jalr 4, load 5. Each wait cycle adds 1.
REQ-025 Wait counter: cleared on entry to FETCH or MEM and on each handshake completion; increments each cycle req=1 and ready=0. Reaching TIMEOUT_CYCLES -> HALT with bus_error=1 and no strobe issued.
REQ-026 HALT: finished=1. All strobes and reqs 0. Stays until reset; start ignored.
REQ-027 Outside their defined states, strobes, imem_req and dmem_req SHALL be 0. A ready input with no matching req is ignored.

Reset
REQ-028 On reset=1 at an edge: state=IDLE, opcode_q=0, wait counter=0, instr_count=0, illegal=0, bus_error=0.
REQ-029 While in IDLE, all outputs are 0.
REQ-030 Reset has priority over every transition, including mid-handshake; a pending req drops in the cycle after the reset edge.

Verification
REQ-031 R-type, start pulse, imem_ready tied 1 -> states 1,2,3,5. rf_write_en and pc_write_en high in cycle 4 with wb_sel=00. instr_count=1.
REQ-032 Load with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, then WB with wb_sel=01. Total 8 cycles. dm_write_en never 1.
REQ-033 Branch with branch_taken=1 then 0 -> pc_src=01 then 00 in EXEC. rf_write_en never 1. 3 cycles each.
REQ-034 opcode 1111111 -> HALT, illegal=1, finished=1, instr_count unchanged. opcode 1110011 -> HALT, illegal=0.
REQ-035 imem_ready held 0 with TIMEOUT_CYCLES=4 -> bus_error=1 and HALT after 4 cycles. A following reset -> IDLE, all flags 0.
REQ-036 Reset asserted during MEM wait of a store -> dm_write_en never asserted, dmem_req low next cycle, state=0.
